mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: rst  input  1  synchronous, active-low reset (rst=0 sampled at a rising edge resets the block).
- REQ-003: flush  input  1  pipeline flush (exception/eret); aborts any operation in progress.
- REQ-004: start  input  1  level request from EX; high while EX holds a mult/div instruction.
- REQ-005: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- REQ-006: operand_1  input  32  multiplicand / dividend; sampled with start.
- REQ-007: operand_2  input  32  multiplier / divisor; sampled with start.
- REQ-008: done  output  1  result valid; EX stall is !done.
- REQ-009: result  output  64  MULT/MULTU: {product[63:32], product[31:0]}; DIV/DIVU: {remainder, quotient}, i.e. {hi, lo}.

Function
- REQ-010: State machine with three states: IDLE, BUSY, DONE.
- REQ-011: IDLE: if start=1 and flush=0 -> latch op, operand magnitudes and sign flags, clear the iteration counter, go to BUSY; otherwise stay in IDLE.
- REQ-012: BUSY: one iteration per cycle, counter 0..31; after iteration 31 -> DONE; 32 BUSY cycles in total.
- REQ-013: Multiply: shift-add over the 32 bits of the unsigned magnitudes; 64-bit accumulator.
- REQ-014: Divide: restoring radix-2 over the unsigned magnitudes; 32-bit quotient and 33-bit partial remainder.
- REQ-015: Signed ops (MULT, DIV) use two's-complement magnitudes; sign fix-up is applied when the result register is loaded on the BUSY->DONE edge.
  - Product sign = sign1 XOR sign2.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign of the dividend.
- REQ-016: Unsigned ops (MULTU, DIVU) use the operands unmodified; no sign fix-up.
- REQ-017: Latency: start accepted in IDLE at cycle N; BUSY during N+1..N+32; done=1 during cycle N+33 only; IDLE from N+34.
- REQ-018: done is registered; it is 1 only in DONE; result changes only on the BUSY->DONE edge and holds its value until the next BUSY->DONE edge.
- REQ-019: DONE always returns to IDLE after one cycle, ignoring start, so the still-present instruction is not restarted.
- REQ-020: Back-to-back ops: a new start seen in the IDLE cycle after DONE is accepted normally.
- REQ-021: Divide by zero (operand_2=0), DIV or DIVU: full 32-cycle latency; quotient=32'hFFFFFFFF; remainder=operand_1 as given; no sign fix-up.
- REQ-022: DIV 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (wraps, no trap).
- REQ-023: MULT with operand 0x80000000 computes its magnitude as 33-bit unsigned 2^31, not 0x80000000 negated in 32 bits.
- REQ-024: flush=1 in any state -> IDLE at the next edge; done=0; result unchanged; flush has priority over start.
- REQ-025: op, operand_1 and operand_2 changing during BUSY have no effect on the result.
- REQ-026: The block never asserts done without a prior accepted start.

Reset
- REQ-027: rst=0 at a rising edge -> state IDLE, done=0, result=0, counter=0, internal accumulators=0.
- REQ-028: Reset has priority over flush and start.
- REQ-029: Reset mid-BUSY abandons the operation; no done pulse follows.
- REQ-030: After rst returns to 1, the first start is accepted in the next cycle.

Verification
- REQ-031: MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at cycle N -> done=1 only at N+33, result=64'hFFFFFFFE_00000001.
- REQ-032: MULT 0xFFFFFFFE (-2) x 0x00000003 -> result=64'hFFFFFFFF_FFFFFFFA; DIV 0xFFFFFFF9 (-7) / 2 -> result={0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quot -3).
- REQ-033: DIVU 100 / 0 -> done at N+33, result={0x00000064, 0xFFFFFFFF}; DIV 0x80000000 / 0xFFFFFFFF -> result={0, 0x80000000}.
- REQ-034: Hold start=1 through DONE with MULTU 3x5 -> a single done pulse, result=15, IDLE at N+34; then assert start with DIVU 10/3 -> result={1, 3} at 33 cycles after acceptance.
- REQ-035: Flush at N+10 -> IDLE at N+11, done never pulses, result keeps its prior value; rst=0 at N+20 of a new op -> done=0, result=0, no later done pulse.
- REQ-036: Randomised signed/unsigned operands against a reference model, including 0, 1, -1, 0x80000000 and 0x7FFFFFFF -> all results match.

Source files
------------

// File: rtl/mult_div.sv
// Iterative 32-bit multiply/divide unit for a MIPS-style EX stage.
// MULT/MULTU use a shift-add over 32 cycles. DIV/DIVU use a restoring radix-2
// divide over 32 cycles. Both work on unsigned magnitudes, and a sign fix-up
// is applied when the result register is loaded. done pulses for one cycle.
// After that pulse the unit always returns to IDLE, so a start that is still
// held does not relaunch the same instruction.
module mult_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        done_reg, done_next;

    // hi_reg: multiply upper accumulator or divide partial remainder.
    // lo_reg: multiply multiplier/low product or divide dividend/quotient.
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] b_reg, b_next;          // multiplicand / divisor magnitude
    logic [4:0]  cnt_reg, cnt_next;
    logic        is_div_reg, is_div_next;
    logic        neg_q_reg, neg_q_next;  // product / quotient negate
    logic        neg_r_reg, neg_r_next;  // remainder negate (dividend sign)
    logic        div_zero_reg, div_zero_next;
    logic [63:0] result_reg, result_next;

    // FSM control strobes
    logic        accept;
    logic        iterate;
    logic        finish;

    // Operand conditioning: signed ops take two's-complement magnitudes.
    // Negating 0x80000000 in 32 bits gives 0x80000000. Read as unsigned, that
    // value is 2^31, which is exactly the required magnitude. It therefore
    // needs no extra bit.
    logic        op_signed;
    logic        sign_1, sign_2;
    logic [31:0] mag_1, mag_2;

    assign op_signed = ~op[0];
    assign sign_1    = op_signed & operand_1[31];
    assign sign_2    = op_signed & operand_2[31];
    assign mag_1     = sign_1 ? (32'd0 - operand_1) : operand_1;
    assign mag_2     = sign_2 ? (32'd0 - operand_2) : operand_2;

    // One iteration of either algorithm.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;   // 33-bit partial remainder, before the trial subtract
    logic        div_ge;
    logic [31:0] div_sub;
    logic [31:0] hi_step, lo_step;

    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : 33'd0);
    assign div_shift = {hi_reg, lo_reg[31]};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
    // When div_ge holds, the true difference is below the divisor, so it fits in 32 bits.
    assign div_sub   = div_shift[31:0] - b_reg;

    // Select the next hi/lo for the active algorithm.
    always_comb begin
        hi_step = hi_reg;
        lo_step = lo_reg;
        if (is_div_reg) begin
            if (div_ge) begin
                hi_step = div_sub;
                lo_step = {lo_reg[30:0], 1'b1};
            end else begin
                hi_step = div_shift[31:0];
                lo_step = {lo_reg[30:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[32:1];
            lo_step = {mul_sum[0], lo_reg[31:1]};
        end
    end

    // Sign fix-up of the final iteration's outcome.
    // A divide by zero leaves the quotient as all ones. The remainder
    // magnitude equals |operand_1|, so restoring the dividend sign
    // reproduces operand_1 exactly.
    logic [63:0] prod_raw, prod_fixed;
    logic [31:0] quot_fixed, rem_fixed;
    logic [63:0] final_result;

    assign prod_raw     = {hi_step, lo_step};
    assign prod_fixed   = neg_q_reg ? (64'd0 - prod_raw) : prod_raw;
    assign quot_fixed   = (neg_q_reg && !div_zero_reg) ? (32'd0 - lo_step) : lo_step;
    assign rem_fixed    = neg_r_reg ? (32'd0 - hi_step) : hi_step;
    assign final_result = is_div_reg ? {rem_fixed, quot_fixed} : prod_fixed;

    // Next-state and control: flush aborts from any state; DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        accept     = 1'b0;
        iterate    = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    iterate = 1'b1;
                    if (cnt_reg == 5'd31) begin
                        finish     = 1'b1;
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath next values: latch operands on accept, step while busy, load result on finish.
    always_comb begin
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        b_next        = b_reg;
        cnt_next      = cnt_reg;
        is_div_next   = is_div_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        div_zero_next = div_zero_reg;
        result_next   = result_reg;
        if (accept) begin
            hi_next       = 32'd0;
            lo_next       = mag_1;
            b_next        = mag_2;
            cnt_next      = 5'd0;
            is_div_next   = op[1];
            neg_q_next    = sign_1 ^ sign_2;
            neg_r_next    = sign_1;
            div_zero_next = op[1] & (operand_2 == 32'd0);
        end else if (iterate) begin
            hi_next  = hi_step;
            lo_next  = lo_step;
            cnt_next = cnt_reg + 5'd1;
            if (finish) begin
                result_next = final_result;
            end
        end
    end

    // State and done register; reset dominates flush and start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    // Datapath registers; reset clears accumulators, counter and result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            b_reg        <= 32'd0;
            cnt_reg      <= 5'd0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            result_reg   <= 64'd0;
        end else begin
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            b_reg        <= b_next;
            cnt_reg      <= cnt_next;
            is_div_reg   <= is_div_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            div_zero_reg <= div_zero_next;
            result_reg   <= result_next;
        end
    end

    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_mult_div.sv
// Directed testbench for mult_div: latency, signed fix-up, divide by zero,
// back-to-back issue, flush, reset priority and a table of corner operands.
module tb_mult_div;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        done;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;

    mult_div dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op. Start is dropped and the inputs are scrambled during BUSY.
    // The task watches 40 cycles after acceptance, recording the first done
    // cycle offset and the number of done pulses.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int first, output int pulses, output logic [63:0] res);
        first  = -1;
        pulses = 0;
        res    = '0;
        @(negedge clk);
        op        = o;
        operand_1 = a;
        operand_2 = b;
        start     = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (k == 1) begin
                start     = 1'b0;
                op        = ~o;
                operand_1 = ~a;
                operand_2 = b ^ 32'h5A5A_A5A5;
            end
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    res   = result;
                end
            end
            @(posedge clk);
        end
        $display("op=%0d a=%h b=%h result=%h done_at=+%0d pulses=%0d", o, a, b, res, first, pulses);
    endtask

    task automatic test_reset();
        int saw;
        saw = 0;
        rst = 1'b0; flush = 1'b0; start = 1'b1;
        op = OP_MULTU; operand_1 = 32'd3; operand_2 = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        start = 1'b0;
        rst   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) saw++;
        end
        checks++;
        if (saw != 0) begin errors++; $display("FAIL reset_no_spurious_done: got %0d pulses expected 0", saw); end
        $display("reset: done=%b result=%h spurious_pulses=%0d", done, result, saw);
    endtask

    task automatic test_multu_max();
        int first, pulses; logic [63:0] res;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, first, pulses, res);
        checks++;
        if (first != 33) begin errors++; $display("FAIL multu_max_latency: got %0d expected 33", first); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL multu_max_pulses: got %0d expected 1", pulses); end
        checks++;
        if (res !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max_result: got %h expected fffffffe00000001", res); end
    endtask

    task automatic test_signed();
        int first, pulses; logic [63:0] res;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, first, pulses, res);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_neg2x3: got %h expected fffffffffffffffa", res); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, first, pulses, res);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg7by2: got %h expected fffffffffffffffd", res); end
        checks++;
        if (first != 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", first); end
    endtask

    task automatic test_div_zero();
        int first, pulses; logic [63:0] res;
        run_op(OP_DIVU, 32'd100, 32'd0, first, pulses, res);
        checks++;
        if (first != 33) begin errors++; $display("FAIL divu_zero_latency: got %0d expected 33", first); end
        checks++;
        if (res !== 64'h0000_0064_FFFF_FFFF) begin errors++; $display("FAIL divu_zero_result: got %h expected 00000064ffffffff", res); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, first, pulses, res);
        checks++;
        if (res !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_min_by_neg1: got %h expected 0000000080000000", res); end
    endtask

    task automatic test_back_to_back();
        int first1, pulses1, first2, pulses2;
        logic [63:0] res1, res2;
        first1 = -1; pulses1 = 0; first2 = -1; pulses2 = 0; res1 = '0; res2 = '0;
        @(negedge clk);
        op = OP_MULTU; operand_1 = 32'd3; operand_2 = 32'd5; start = 1'b1;
        @(posedge clk);
        // start stays high through DONE; at N+34 (IDLE) the inputs switch to DIVU 10/3
        for (int k = 1; k <= 34; k++) begin
            #1;
            if (done) begin
                pulses1++;
                if (first1 < 0) begin first1 = k; res1 = result; end
            end
            if (k == 34) begin
                op = OP_DIVU; operand_1 = 32'd10; operand_2 = 32'd3;
            end
            @(posedge clk);
        end
        for (int j = 1; j <= 40; j++) begin
            #1;
            if (j == 1) start = 1'b0;
            if (done) begin
                pulses2++;
                if (first2 < 0) begin first2 = j; res2 = result; end
            end
            @(posedge clk);
        end
        $display("b2b: multu done_at=+%0d pulses=%0d result=%h; divu done_at=+%0d pulses=%0d result=%h",
                 first1, pulses1, res1, first2, pulses2, res2);
        checks++;
        if (pulses1 != 1) begin errors++; $display("FAIL b2b_single_pulse: got %0d expected 1", pulses1); end
        checks++;
        if (first1 != 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", first1); end
        checks++;
        if (res1 !== 64'd15) begin errors++; $display("FAIL b2b_first_result: got %h expected 000000000000000f", res1); end
        checks++;
        if (first2 != 33) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 33", first2); end
        checks++;
        if (pulses2 != 1) begin errors++; $display("FAIL b2b_second_pulses: got %0d expected 1", pulses2); end
        checks++;
        if (res2 !== 64'h0000_0001_0000_0003) begin errors++; $display("FAIL b2b_second_result: got %h expected 0000000100000003", res2); end
    endtask

    task automatic test_flush();
        int first, pulses, saw; logic [63:0] res;
        saw = 0;
        run_op(OP_MULTU, 32'd3, 32'd5, first, pulses, res);
        checks++;
        if (res !== 64'd15) begin errors++; $display("FAIL flush_setup_result: got %h expected 000000000000000f", res); end
        @(negedge clk);
        op = OP_MULTU; operand_1 = 32'd7; operand_2 = 32'd7; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (k == 1) start = 1'b0;
            if (done) saw++;
            if (k == 10) flush = 1'b1;
            @(posedge clk);
        end
        #1;
        flush = 1'b0;
        if (done) saw++;
        checks++;
        if (result !== 64'd15) begin errors++; $display("FAIL flush_result_held: got %h expected 000000000000000f", result); end
        // Accepting a new op in N+11 with the usual latency shows the unit was in IDLE.
        run_op(OP_DIVU, 32'd10, 32'd3, first, pulses, res);
        checks++;
        if (first != 33) begin errors++; $display("FAIL flush_idle_after: got done at +%0d expected +33", first); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL flush_no_stale_done: got %0d pulses expected 1", pulses); end
        checks++;
        if (saw != 0) begin errors++; $display("FAIL flush_done_pulsed: got %0d pulses expected 0", saw); end
        checks++;
        if (res !== 64'h0000_0001_0000_0003) begin errors++; $display("FAIL flush_followup_result: got %h expected 0000000100000003", res); end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic test_vectors();
        vec_t vecs[$];
        int first, pulses; logic [63:0] res;
        vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
        vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{OP_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001});
        vecs.push_back('{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001});
        vecs.push_back('{OP_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000});
        vecs.push_back('{OP_MULTU, 32'h7FFF_FFFF, 32'h0000_0002, 64'h0000_0000_FFFF_FFFE});
        vecs.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000});
        vecs.push_back('{OP_MULTU, 32'h8000_0000, 32'h0000_0001, 64'h0000_0000_8000_0000});
        vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF});
        vecs.push_back('{OP_DIVU,  32'h0000_0005, 32'h0000_0007, 64'h0000_0005_0000_0000});
        vecs.push_back('{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000});
        vecs.push_back('{OP_DIV,   32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_8000_0001});
        vecs.push_back('{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001});
        vecs.push_back('{OP_DIV,   32'h8000_0000, 32'h0000_0002, 64'h0000_0000_C000_0000});
        vecs.push_back('{OP_DIV,   32'h0000_0001, 32'h8000_0000, 64'h0000_0001_0000_0000});
        vecs.push_back('{OP_DIVU,  32'd1000,      32'd7,         64'h0000_0006_0000_008E});
        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, first, pulses, res);
            checks++;
            if (res !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d_result: got %h expected %h", i, res, vecs[i].exp);
            end
            checks++;
            if (first != 33 || pulses != 1) begin
                errors++;
                $display("FAIL vec%0d_timing: got done at +%0d with %0d pulses expected +33 with 1", i, first, pulses);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int saw;
        saw = 0;
        @(negedge clk);
        op = OP_MULTU; operand_1 = 32'h0000_1234; operand_2 = 32'h0000_5678; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (k == 1) start = 1'b0;
            if (done) saw++;
            if (k == 20) rst = 1'b0;
            @(posedge clk);
        end
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b expected 0", done); end
        checks++;
        if (result !== 64'd0) begin errors++; $display("FAIL rst_busy_result: got %h expected 0", result); end
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) saw++;
        end
        checks++;
        if (saw != 0) begin errors++; $display("FAIL rst_busy_no_done: got %0d pulses expected 0", saw); end
        checks++;
        if (result !== 64'd0) begin errors++; $display("FAIL rst_busy_result_after: got %h expected 0", result); end
        $display("reset mid-busy: done=%b result=%h pulses=%0d", done, result, saw);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        op = 2'b00; operand_1 = 32'd0; operand_2 = 32'd0;
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_flush();
        test_vectors();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
